// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store path.
// Serves one multi-cycle access at a time; contention alternates between requesters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              MemR,
    input  logic              MemW,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {FETCH, DATA} req_t;

    state_t           state;
    state_t           state_next;
    req_t             owner;
    req_t             last;
    logic [CNT_W-1:0] cnt;
    logic             data_pend;
    logic             grant;
    logic             grant_data;
    logic             done;

    assign data_pend  = MemR | MemW;
    // On a tie the requester that was not served most recently wins.
    assign grant_data = data_pend & (~if_req | (last == FETCH));
    assign done       = (state == BUSY) && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults come first so no path through this block leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (data_pend || if_req) begin
                    state_next = BUSY;
                    grant      = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (done) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= FETCH;
            last      <= FETCH;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else if (grant) begin
            owner    <= grant_data ? DATA : FETCH;
            mem_en   <= 1'b1;
            mem_we   <= grant_data & MemW;
            mem_addr <= grant_data ? d_addr : if_addr;
            if (grant_data) begin
                mem_wdata <= d_wdata;
            end
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                last   <= owner;
                // Stores leave both read-data registers untouched.
                if (!mem_we) begin
                    if (owner == DATA) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign if_valid = (state == RESP) && (owner == FETCH);
    assign d_valid  = (state == RESP) && (owner == DATA);
    assign stall    = (data_pend & ~d_valid) | (if_req & ~if_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked against
// a transaction-level model (issue cycle, end cycle, response cycle).
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int L  = 2;

    logic          clk;
    logic          reset_n;
    logic          if_req, MemR, MemW;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_valid, d_valid, stall, mem_en, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          if_valid_1, d_valid_1, stall_1, mem_en_1, mem_we_1;
    logic [DW-1:0] if_rdata_1, d_rdata_1, mem_wdata_1, mem_rdata_1;
    logic [AW-1:0] mem_addr_1;

    logic [DW-1:0] tb_mem [256];
    bit            wr_flag [256];
    logic          poke_en;
    logic [7:0]    poke_a;
    logic [DW-1:0] poke_d;

    int n_cmp, n_bad;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
        .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr),
        .if_valid(if_valid), .if_rdata(if_rdata), .MemR(MemR), .MemW(MemW),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr),
        .if_valid(if_valid_1), .if_rdata(if_rdata_1), .MemR(MemR), .MemW(MemW),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_valid(d_valid_1), .d_rdata(d_rdata_1),
        .stall(stall_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    function automatic logic [DW-1:0] pattern(input logic [7:0] a);
        return {a, ~a} ^ 16'h3C5A;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro stand-in: unwritten words read back a fixed address pattern.
    always @(posedge clk) begin
        if (poke_en) begin
            tb_mem[poke_a]  <= poke_d;
            wr_flag[poke_a] <= 1'b1;
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr[7:0]]  <= mem_wdata;
            wr_flag[mem_addr[7:0]] <= 1'b1;
        end
    end
    assign mem_rdata   = wr_flag[mem_addr[7:0]]   ? tb_mem[mem_addr[7:0]]   : pattern(mem_addr[7:0]);
    assign mem_rdata_1 = wr_flag[mem_addr_1[7:0]] ? tb_mem[mem_addr_1[7:0]] : pattern(mem_addr_1[7:0]);

    // Reference model of the L-cycle arbiter, one transaction at a time.
    int            cyc;
    bit            m_active, m_is_data, m_we, m_resp_data, m_last_data;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
    int            m_end, m_resp_cyc;
    logic [DW-1:0] m_mem [256];
    bit            m_wr [256];

    function automatic logic [DW-1:0] m_rd(input logic [7:0] a);
        return m_wr[a] ? m_mem[a] : pattern(a);
    endfunction
    function automatic bit e_if_valid();
        return (cyc == m_resp_cyc) && !m_resp_data;
    endfunction
    function automatic bit e_d_valid();
        return (cyc == m_resp_cyc) && m_resp_data;
    endfunction
    function automatic bit e_stall();
        return ((MemR | MemW) && !e_d_valid()) || (if_req && !e_if_valid());
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_last_data = 1'b0;
        m_resp_cyc  = -1;
        m_if_rdata  = '0;
        m_d_rdata   = '0;
    endtask

    // Called at each rising edge; 'cyc' is the cycle that edge ends.
    task automatic model_edge();
        if (m_active) begin
            if (cyc == m_end) begin
                if (m_we) begin
                    m_mem[m_addr[7:0]] = m_wdata;
                    m_wr[m_addr[7:0]]  = 1'b1;
                end else if (m_is_data) begin
                    m_d_rdata = m_rd(m_addr[7:0]);
                end else begin
                    m_if_rdata = m_rd(m_addr[7:0]);
                end
                m_active    = 1'b0;
                m_resp_cyc  = cyc + 1;
                m_resp_data = m_is_data;
                m_last_data = m_is_data;
            end
        end else if (MemR || MemW || if_req) begin
            m_is_data = (MemR || MemW) && (!if_req || !m_last_data);
            m_we      = m_is_data && MemW;
            m_addr    = m_is_data ? d_addr : if_addr;
            m_wdata   = d_wdata;
            m_active  = 1'b1;
            m_end     = cyc + L;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {if_req, MemR, MemW} = 3'b000;
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en  = 1'b0;
        m_mem[a] = d;
        m_wr[a]  = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return {8'($urandom_range(0, 255)), 4'h0, 4'($urandom_range(0, 15))};
    endfunction

    task automatic test_reset();
        logic [69:0] got;
        do_reset();
        reset_n = 1'b0;
        #1;
        got = {mem_en, mem_we, if_valid, d_valid, stall, if_rdata, d_rdata, mem_addr, mem_wdata, 1'b0};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        reset_n = 1'b1;
        step();
        #1;
        n_cmp++;
        if ({mem_en, if_valid, d_valid, stall} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle got=%b exp=0000", {mem_en, if_valid, d_valid, stall});
        end
    endtask

    task automatic test_fetch();
        logic [4:0] got, exp;
        do_reset();
        poke(8'h10, 16'h1A2B);
        if_req  = 1'b1;
        if_addr = 16'h0010;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_stall0 got=%b exp=1", stall);
        end
        for (int k = 1; k <= L + 1; k++) begin
            step();
            #1;
            got = {mem_en, mem_we, if_valid, d_valid, stall};
            exp = {k <= L, 1'b0, k == L + 1, 1'b0, k <= L};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL fetch_ctrl k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k <= L) begin
                n_cmp++;
                if (mem_addr !== 16'h0010) begin
                    n_bad++;
                    $display("FAIL fetch_addr k=%0d got=%h exp=0010", k, mem_addr);
                end
            end
        end
        n_cmp++;
        if (if_rdata !== 16'h1A2B) begin
            n_bad++;
            $display("FAIL fetch_rdata got=%h exp=1a2b", if_rdata);
        end
        if_req = 1'b0;
        step();
        #1;
        n_cmp++;
        if ({mem_en, if_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_after got=%b exp=00", {mem_en, if_valid});
        end
    endtask

    task automatic test_tie();
        do_reset();
        poke(8'h00, 16'h5A5A);
        poke(8'h11, 16'h1111);
        if_req  = 1'b1;
        if_addr = 16'h0011;
        MemR    = 1'b1;
        d_addr  = 16'h0400;
        step();
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0400}) begin
            n_bad++;
            $display("FAIL tie_first_grant got=%b/%h exp=10/0400", {mem_en, mem_we}, mem_addr);
        end
        repeat (L) step();
        #1;
        n_cmp++;
        if ({mem_en, d_valid, if_valid, stall, d_rdata} !== {4'b0101, 16'h5A5A}) begin
            n_bad++;
            $display("FAIL tie_load_resp got=%b/%h exp=0101/5a5a", {mem_en, d_valid, if_valid, stall}, d_rdata);
        end
        MemR = 1'b0;
        step();
        #1;
        n_cmp++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0011}) begin
            n_bad++;
            $display("FAIL tie_second_grant got=%b/%h exp=1/0011", mem_en, mem_addr);
        end
        repeat (L) step();
        #1;
        n_cmp++;
        if ({if_valid, d_valid, if_rdata} !== {2'b10, 16'h1111}) begin
            n_bad++;
            $display("FAIL tie_fetch_resp got=%b/%h exp=10/1111", {if_valid, d_valid}, if_rdata);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        MemW    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'hBEEF;
        for (int k = 1; k <= L; k++) begin
            step();
            #1;
            n_cmp++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0200, 16'hBEEF}) begin
                n_bad++;
                $display("FAIL store_busy k=%0d got=%b/%h/%h exp=11/0200/beef", k, {mem_en, mem_we}, mem_addr, mem_wdata);
            end
        end
        step();
        #1;
        n_cmp++;
        if ({mem_en, d_valid, if_valid, d_rdata} !== {3'b010, 16'h5A5A}) begin
            n_bad++;
            $display("FAIL store_resp got=%b/%h exp=010/5a5a", {mem_en, d_valid, if_valid}, d_rdata);
        end
        MemW = 1'b0;
        step();
    endtask

    task automatic test_memrw();
        {MemR, MemW} = 2'b11;
        d_addr  = 16'h0200;
        d_wdata = 16'h1234;
        step();
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_wdata} !== {2'b11, 16'h1234}) begin
            n_bad++;
            $display("FAIL rw_write got=%b/%h exp=11/1234", {mem_en, mem_we}, mem_wdata);
        end
        repeat (L) step();
        #1;
        n_cmp++;
        if ({d_valid, d_rdata} !== {1'b1, 16'h5A5A}) begin
            n_bad++;
            $display("FAIL rw_resp got=%b/%h exp=1/5a5a", d_valid, d_rdata);
        end
        MemW = 1'b0;
        repeat (L + 1) step();
        #1;
        n_cmp++;
        if ({d_valid, d_rdata} !== {1'b1, 16'h1234}) begin
            n_bad++;
            $display("FAIL rw_readback got=%b/%h exp=1/1234", d_valid, d_rdata);
        end
        MemR = 1'b0;
        step();
    endtask

    task automatic test_alternate();
        int  ng;
        int  last_rise;
        bit  prev_en;
        bit  exp_data;
        do_reset();
        if_req    = 1'b1;
        if_addr   = 16'h0011;
        MemR      = 1'b1;
        d_addr    = 16'h0400;
        ng        = 0;
        last_rise = 0;
        prev_en   = 1'b0;
        exp_data  = 1'b1;
        for (int k = 0; k < 8 * (L + 1) && ng < 6; k++) begin
            step();
            #1;
            if (mem_en && !prev_en) begin
                n_cmp++;
                if ((mem_addr == 16'h0400) !== exp_data) begin
                    n_bad++;
                    $display("FAIL alt_owner grant=%0d got_addr=%h exp_data=%b", ng, mem_addr, exp_data);
                end
                if (ng > 0) begin
                    n_cmp++;
                    if (k - last_rise !== L + 1) begin
                        n_bad++;
                        $display("FAIL alt_gap grant=%0d got=%0d exp=%0d", ng, k - last_rise, L + 1);
                    end
                end
                exp_data  = !exp_data;
                last_rise = k;
                ng++;
            end
            prev_en = mem_en;
        end
        n_cmp++;
        if (ng != 6) begin
            n_bad++;
            $display("FAIL alt_grants got=%0d exp=6", ng);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        MemR   = 1'b1;
        d_addr = 16'h0300;
        repeat (L + 1) step();
        step();
        step();
        #1;
        n_cmp++;
        if ({mem_en, d_rdata} !== {1'b1, pattern(8'h00) === m_rd(8'h00) ? m_rd(8'h00) : m_rd(8'h00)}) begin
            n_bad++;
            $display("FAIL rmid_busy got=%b/%h exp=1/%h", mem_en, d_rdata, m_rd(8'h00));
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({mem_en, mem_we, d_valid, mem_addr, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rmid_async got=%b/%h/%h exp=000/0000/0000", {mem_en, mem_we, d_valid}, mem_addr, d_rdata);
        end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_en, d_valid} !== 2'b00) begin
                n_bad++;
                $display("FAIL rmid_hold got=%b exp=00", {mem_en, d_valid});
            end
        end
        reset_n = 1'b1;
        if_req  = 1'b1;
        if_addr = 16'h0011;
        step();
        #1;
        n_cmp++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0300}) begin
            n_bad++;
            $display("FAIL rmid_tie got=%b/%h exp=1/0300", mem_en, mem_addr);
        end
        do_reset();
    endtask

    task automatic test_lat1();
        int k;
        int en_cnt;
        bit seen;
        do_reset();
        MemR    = 1'b1;
        d_addr  = 16'h0033;
        d_wdata = 16'h7777;
        k = 0; en_cnt = 0; seen = 1'b0;
        while (!seen && k < 10) begin
            step();
            k++;
            #1;
            if (mem_en_1 === 1'b1) begin
                en_cnt++;
                n_cmp++;
                if ({mem_we_1, mem_wdata_1, mem_addr_1} !== {1'b0, 16'h7777, 16'h0033}) begin
                    n_bad++;
                    $display("FAIL lat1_issue got=%b/%h/%h exp=0/7777/0033", mem_we_1, mem_wdata_1, mem_addr_1);
                end
            end
            if (d_valid_1 === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || k != 2 || en_cnt != 1 || d_rdata_1 !== pattern(8'h33)) begin
            n_bad++;
            $display("FAIL lat1_load seen=%b lat=%0d en=%0d data=%h exp=1/2/1/%h", seen, k, en_cnt, d_rdata_1, pattern(8'h33));
        end
        MemR    = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0044;
        k = 0; seen = 1'b0;
        while (!seen && k < 10) begin
            step();
            k++;
            #1;
            if (if_valid_1 === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || k != 2 || if_rdata_1 !== pattern(8'h44) || stall_1 !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1_fetch seen=%b lat=%0d data=%h stall=%b exp=1/2/%h/0", seen, k, if_rdata_1, pattern(8'h44), stall_1);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_random(input int n);
        bit          ev_i, ev_d;
        logic [36:0] got, exp;
        do_reset();
        for (int k = 0; k < n; k++) begin
            ev_i = e_if_valid();
            ev_d = e_d_valid();
            if (if_req && m_active && !m_is_data && $urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end else if (ev_i || !if_req) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if ((MemR || MemW) && m_active && m_is_data && $urandom_range(0, 15) == 0) begin
                {MemR, MemW} = 2'b00;
            end else if (ev_d || !(MemR || MemW)) begin
                case ($urandom_range(0, 5))
                    0, 1:    {MemR, MemW} = 2'b10;
                    2:       {MemR, MemW} = 2'b01;
                    3:       {MemR, MemW} = 2'b11;
                    default: {MemR, MemW} = 2'b00;
                endcase
                d_addr  = rand_addr();
                d_wdata = 16'($urandom);
            end
            #1;
            got = {mem_en, mem_we, if_valid, d_valid, stall, if_rdata, d_rdata};
            exp = {m_active, m_active && m_we, ev_i, ev_d, e_stall(), m_if_rdata, m_d_rdata};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL rnd_outputs cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
            if (m_active) begin
                n_cmp++;
                if (mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata)) begin
                    n_bad++;
                    $display("FAIL rnd_addr_wdata cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_addr, mem_wdata, m_addr, m_wdata);
                end
            end
            step();
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        poke_en = 1'b0;
        poke_a  = '0;
        poke_d  = '0;
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_memrw();
        test_alternate();
        test_reset_mid();
        test_lat1();
        test_random(1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
